// File: rtl/alu_src_pkg.sv
// Shared definitions for the ALU B-operand select stage.
// Select encodings and beat packing helpers.
package alu_src_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SRC_REG      = 3'b000;
    localparam logic [SEL_W-1:0] SRC_CONST    = 3'b001;
    localparam logic [SEL_W-1:0] SRC_SEXT     = 3'b010;
    localparam logic [SEL_W-1:0] SRC_SEXT_SH2 = 3'b011;
    localparam logic [SEL_W-1:0] SRC_ZEXT     = 3'b100;
    localparam logic [SEL_W-1:0] SRC_LUI      = 3'b101;

    // A beat is packed as {err, data}.
    function automatic int beat_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/alu_src_b_gen.sv
// Combinational B-operand and illegal-select generation.
// Optional writeback bypass on the register source: ALUSRCB_FWD_EN.
import alu_src_pkg::*;

module alu_src_b_gen #(
    parameter int          DATA_W    = 32,
    parameter int          IMM_W     = 16,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic [DATA_W-1:0] reg_b_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic [SEL_W-1:0]  sel,
`ifdef ALUSRCB_FWD_EN
    input  logic              fwd_valid,
    input  logic [DATA_W-1:0] fwd_data,
`endif
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [DATA_W-1:0] reg_src;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] lui;

`ifdef ALUSRCB_FWD_EN
    assign reg_src = fwd_valid ? fwd_data : reg_b_data;
`else
    assign reg_src = reg_b_data;
`endif

    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign lui  = {imm, {(DATA_W-IMM_W){1'b0}}};

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (sel)
            SRC_REG:      data = reg_src;
            SRC_CONST:    data = DATA_W'(CONST_VAL);
            SRC_SEXT:     data = sext;
            SRC_SEXT_SH2: data = sext << 2;
            SRC_ZEXT:     data = zext;
            SRC_LUI:      data = lui;
            default:      err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_src_b_stage.sv
// Registered ALU B-operand select with a 2-entry skid buffer.
// Optional writeback bypass ports: ALUSRCB_FWD_EN.
import alu_src_pkg::*;

module alu_src_b_stage #(
    parameter int          DATA_W    = 32,
    parameter int          IMM_W     = 16,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] reg_b_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic [SEL_W-1:0]  sel,
`ifdef ALUSRCB_FWD_EN
    input  logic              fwd_valid,
    input  logic [DATA_W-1:0] fwd_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel_err
);

    localparam int BW = beat_w(DATA_W);

    logic [DATA_W-1:0] gen_data;
    logic              gen_err;
    logic [BW-1:0]     beat_d;
    logic [BW-1:0]     o_q;
    logic [BW-1:0]     s_q;
    logic              o_full;
    logic              s_full;
    logic              accept;

    alu_src_b_gen #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .CONST_VAL (CONST_VAL)
    ) u_gen (
        .reg_b_data (reg_b_data),
        .imm        (imm),
        .sel        (sel),
`ifdef ALUSRCB_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_data   (fwd_data),
`endif
        .data       (gen_data),
        .err        (gen_err)
    );

    assign beat_d = {gen_err, gen_data};
    assign accept = in_valid && !s_full;

    // S can only be full while O is full, so O never empties from that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_q    <= '0;
            s_q    <= '0;
            o_full <= 1'b0;
            s_full <= 1'b0;
        end else if (s_full) begin
            if (out_ready) begin
                o_q    <= s_q;
                s_full <= 1'b0;
            end
        end else if (accept) begin
            if (!o_full || out_ready) begin
                o_q    <= beat_d;
                o_full <= 1'b1;
            end else begin
                s_q    <= beat_d;
                s_full <= 1'b1;
            end
        end else if (out_ready) begin
            o_full <= 1'b0;
        end
    end

    assign in_ready    = !s_full;
    assign out_valid   = o_full;
    assign out_data    = o_q[DATA_W-1:0];
    assign out_sel_err = o_q[DATA_W];

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed self-checking bench for alu_src_b_stage.
// Bypass vectors run only when ALUSRCB_FWD_EN is defined.
module tb_alu_src_b_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg_b_data;
    logic [15:0] imm;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sel_err;
`ifdef ALUSRCB_FWD_EN
    logic        fwd_valid;
    logic [31:0] fwd_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_src_b_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reg_b_data  (reg_b_data),
        .imm         (imm),
        .sel         (sel),
`ifdef ALUSRCB_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_data    (fwd_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel_err (out_sel_err)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_tab [6];

    initial begin
        exp_tab[0] = 32'h12345678;
        exp_tab[1] = 32'h00000004;
        exp_tab[2] = 32'hFFFFFFFC;
        exp_tab[3] = 32'hFFFFFFF0;
        exp_tab[4] = 32'h0000FFFC;
        exp_tab[5] = 32'hFFFC0000;

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        reg_b_data = 32'h12345678;
        imm        = 16'hFFFC;
        sel        = 3'b000;
`ifdef ALUSRCB_FWD_EN
        fwd_valid  = 1'b0;
        fwd_data   = 32'h0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_err", 64'(out_sel_err), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);

        // single beats, one per source
        for (int i = 0; i < 6; i++) begin
            sel      = 3'(i);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("src%0d_ov", i), 64'(out_valid), 64'd1);
            check($sformatf("src%0d_data", i), 64'(out_data),
                  64'(exp_tab[i]));
            check($sformatf("src%0d_err", i), 64'(out_sel_err), 64'd0);
        end
        @(negedge clk);
        check("idle_ov", 64'(out_valid), 64'd0);

        // illegal select then recovery
        sel      = 3'b110;
        imm      = 16'h1234;
        in_valid = 1'b1;
        @(negedge clk);
        check("ill_data", 64'(out_data), 64'd0);
        check("ill_err", 64'(out_sel_err), 64'd1);
        sel = 3'b111;
        @(negedge clk);
        check("ill7_err", 64'(out_sel_err), 64'd1);
        sel = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        check("rec_data", 64'(out_data), 64'd4);
        check("rec_err", 64'(out_sel_err), 64'd0);
        @(negedge clk);

        // backpressure: A,B fill O and S, C waits
        out_ready = 1'b0;
        sel       = 3'b010;
        imm       = 16'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("bp_a_ov", 64'(out_valid), 64'd1);
        check("bp_a_data", 64'(out_data), 64'd1);
        check("bp_a_rdy", 64'(in_ready), 64'd1);
        imm = 16'd2;
        @(negedge clk);
        check("bp_b_rdy", 64'(in_ready), 64'd0);
        check("bp_b_hold", 64'(out_data), 64'd1);
        imm = 16'd3;
        @(negedge clk);
        check("bp_c_rdy", 64'(in_ready), 64'd0);
        check("bp_c_hold", 64'(out_data), 64'd1);
        check("bp_c_ov", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out2", 64'(out_data), 64'd2);
        check("bp_out2_ov", 64'(out_valid), 64'd1);
        check("bp_out2_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out3", 64'(out_data), 64'd3);
        check("bp_out3_ov", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_drain_ov", 64'(out_valid), 64'd0);

        // throughput: one beat per cycle
        sel = 3'b010;
        for (int i = 0; i < 16; i++) begin
            imm      = 16'(i);
            in_valid = 1'b1;
            if (i > 0) begin
                check($sformatf("tp%0d_data", i - 1), 64'(out_data),
                      64'(i - 1));
                check($sformatf("tp%0d_ov", i - 1), 64'(out_valid), 64'd1);
            end
            check($sformatf("tp%0d_rdy", i), 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("tp15_data", 64'(out_data), 64'd15);
        check("tp15_ov", 64'(out_valid), 64'd1);
        @(negedge clk);

        // async reset with O and S both full
        out_ready = 1'b0;
        sel       = 3'b001;
        in_valid  = 1'b1;
        @(negedge clk);
        sel = 3'b100;
        imm = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_full_rdy", 64'(in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("ar_ov", 64'(out_valid), 64'd0);
        check("ar_data", 64'(out_data), 64'd0);
        check("ar_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ar_no_stale", 64'(out_valid), 64'd0);
        end

`ifdef ALUSRCB_FWD_EN
        sel        = 3'b000;
        reg_b_data = 32'h1;
        fwd_valid  = 1'b1;
        fwd_data   = 32'hCAFEF00D;
        in_valid   = 1'b1;
        @(negedge clk);
        check("fwd_reg", 64'(out_data), 64'hCAFEF00D);
        sel = 3'b010;
        imm = 16'h0008;
        @(negedge clk);
        in_valid = 1'b0;
        check("fwd_ignored", 64'(out_data), 64'h8);
        fwd_valid = 1'b0;
        sel       = 3'b000;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("fwd_off", 64'(out_data), 64'h1);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_src_b_stage.md
Name: alu_src_b_stage

Overview:
Parametrised, registered successor to the ALU B-operand select.
- Generates the operand from six sources: register B, a constant, and four immediate forms (sign-extend, sign-extend with shift-left-2, zero-extend, LUI).
- Delivers the operand through a 2-entry skid buffer with valid/ready handshake, so the operand path can be pipelined between register read and the ALU.
- Each beat carries its own illegal-select flag.

Parameters:
- DATA_W, 32, operand width; must be at least IMM_W+2.
- IMM_W, 16, width of the raw immediate field.
- CONST_VAL, 4, value of the constant source, zero-extended to DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- reg_b_data  input  DATA_W  register B value.
- imm  input  IMM_W  raw immediate.
- sel  input  3  source select (ALUSrcB).
- out_valid  output  1  operand beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  selected operand.
- out_sel_err  output  1  beat was produced from an illegal sel.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel_err=0, skid entry empty, in_ready=1 from the first edge after reset deasserts.
- Source encoding:
  - 000 reg_b_data
  - 001 CONST_VAL
  - 010 sign-extend(imm)
  - 011 sign-extend(imm)<<2, dropping bits above DATA_W-1
  - 100 zero-extend(imm)
  - 101 imm<<(DATA_W-IMM_W), low bits zero
  - 110/111 illegal: data=0, err=1
- Operand generation is combinational on the input side. Data and err are captured together.
- Handshake:
  - Accept = in_valid && in_ready.
  - Emit = out_valid && out_ready.
  - Inputs are sampled only on accept. sel and data may change freely otherwise.
- Output register (O) and skid register (S):
  - Accept with O empty, or O emitting this cycle, and S empty: load O. Latency 1 cycle.
  - Accept while O is full and not emitting: load S.
  - Emit with S full: O loads from S and S empties in the same cycle. A new accept is impossible this cycle because in_ready=0.
  - Emit with S empty and no accept: out_valid falls.
- in_ready = !S_full, driven from a register with no combinational path from out_ready.
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_data and out_sel_err hold stable.
- Full condition: O and S both full gives in_ready=0. in_valid is ignored.
- Simultaneous accept and emit:
  - With S empty: O is replaced by the new beat and out_valid stays 1.
  - With S full: only the shift from S to O occurs.
- Reset mid-operation: both entries are discarded immediately, with outputs at reset values asynchronously. There is no flush of in-flight beats.

Optional Feature:
- Macro: ALUSRCB_FWD_EN.
- Defined:
  - Adds ports fwd_valid (input, 1) and fwd_data (input, DATA_W).
  - When sel=000 and fwd_valid=1 at accept, fwd_data is captured instead of reg_b_data. This is the writeback bypass.
  - Other sel values ignore the forward.
- Undefined: the ports do not exist and sel=000 always uses reg_b_data.

Decomposition:
- Package alu_src_pkg:
  - localparams for the sel encodings: SRC_REG, SRC_CONST, SRC_SEXT, SRC_SEXT_SH2, SRC_ZEXT, SRC_LUI.
  - SEL_W=3.
  - A typedef for the {err, data} beat struct parameterised by DATA_W, or an equivalent packed width constant.
- Sub-module alu_src_b_gen: purely combinational operand and err generation from sel/imm/reg_b_data (and fwd, when enabled).
- The top holds the O/S skid registers and the handshake.

Test Plan:
- Reset then single beats, out_ready=1, imm=16'hFFFC, reg_b_data=32'h12345678:
  - sel=000 → 32'h12345678, err=0
  - sel=001 → 32'h00000004
  - sel=010 → 32'hFFFFFFFC
  - sel=011 → 32'hFFFFFFF0
  - sel=100 → 32'h0000FFFC
  - sel=101 → 32'hFFFC0000
  - each beat appears one cycle after accept.
- Illegal select: sel=110 with imm=16'h1234 → out_data=0, out_sel_err=1. The next beat with sel=001 gives err=0 and data 4.
- Backpressure: out_ready=0, three consecutive in_valid beats A=1, B=2, C=3. A and B are accepted, then in_ready=0 and C is held. Raise out_ready → outputs 1, 2, 3 in order, no gaps after the first, out_data stable while stalled.
- Throughput: out_ready=1 and in_valid=1 continuously for 16 beats with sel=010 and imm=0..15 → 16 outputs on 16 consecutive cycles, in_ready never drops.
- Async reset: assert reset mid-cycle with O and S full → out_valid=0, out_data=0, in_ready=1 before the next clock edge. No stale beats appear after release.
- With ALUSRCB_FWD_EN: sel=000, fwd_valid=1, fwd_data=32'hCAFEF00D, reg_b_data=32'h1 → 32'hCAFEF00D. Then sel=010 with fwd_valid=1 and imm=16'h0008 → 32'h00000008.
